// File: rtl/dpram_sample_unpacker.sv
// Read-side sequencer for the narrow-write/wide-read sample DPRAM.
// Fetches a run of wide words, splits each one into narrow samples (lane 0
// first) and streams them out on a valid/ready interface.
module dpram_sample_unpacker #(
  parameter int unsigned SAMPLE_WIDTH       = 14,
  parameter int unsigned WORD_WIDTH         = 224,
  parameter int unsigned READ_ADDRESS_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [READ_ADDRESS_WIDTH-1:0] startAddr,
  input  logic [READ_ADDRESS_WIDTH:0]   wordCount,
  output logic [READ_ADDRESS_WIDTH-1:0] rAddr,
  input  logic [WORD_WIDTH-1:0]         rData,
  output logic [SAMPLE_WIDTH-1:0]       sampleData,
  output logic [READ_ADDRESS_WIDTH+$clog2(WORD_WIDTH/SAMPLE_WIDTH)-1:0] sampleIndex,
  output logic                          sampleValid,
  input  logic                          sampleReady,
  output logic                          sampleLast,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned RAW     = READ_ADDRESS_WIDTH;
  localparam int unsigned CW      = READ_ADDRESS_WIDTH + 1;
  localparam int unsigned SPC     = WORD_WIDTH / SAMPLE_WIDTH;
  localparam int unsigned LOG_SPC = $clog2(SPC);
  localparam int unsigned LANE_W  = (LOG_SPC > 0) ? LOG_SPC : 1;
  localparam int unsigned SIW     = READ_ADDRESS_WIDTH + LOG_SPC;

  // Word must split into a power-of-two number of whole samples.
  if ((WORD_WIDTH % SAMPLE_WIDTH) != 0 || SPC == 0 || (SPC & (SPC - 1)) != 0) begin : gBadRatio
    $error("dpram_sample_unpacker: WORD_WIDTH/SAMPLE_WIDTH must be a power of two");
  end

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, EMIT} stateT;

  stateT                 state, stateNext;
  logic [RAW-1:0]        rAddrNext;
  logic [CW-1:0]         wordsLeft, wordsLeftNext;
  logic [WORD_WIDTH-1:0] shiftReg, shiftNext;
  logic [LANE_W-1:0]     lane, laneNext;
  logic [SIW-1:0]        indexNext;
  logic                  validNext, lastNext, busyNext, doneNext;
  logic                  accept, lastLane;

  assign accept     = sampleValid && sampleReady;
  assign lastLane   = (lane == LANE_W'(SPC - 1));
  assign sampleData = shiftReg[SAMPLE_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode; abort always returns to IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (start && !abort && wordCount != '0) stateNext = FETCH;
      FETCH: stateNext = abort ? IDLE : WAIT;
      WAIT:  stateNext = abort ? IDLE : EMIT;
      EMIT: begin
        if (abort)                    stateNext = IDLE;
        else if (accept && lastLane)  stateNext = (wordsLeft > CW'(1)) ? FETCH : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    rAddrNext     = rAddr;
    wordsLeftNext = wordsLeft;
    shiftNext     = shiftReg;
    laneNext      = lane;
    indexNext     = sampleIndex;
    validNext     = sampleValid;
    busyNext      = busy;
    doneNext      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (wordCount != '0) begin
            rAddrNext     = startAddr;
            wordsLeftNext = wordCount;
            indexNext     = SIW'(startAddr) << LOG_SPC;
            busyNext      = 1'b1;
          end else begin
            doneNext = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          busyNext  = 1'b0;
          validNext = 1'b0;
        end
      end
      WAIT: begin
        if (abort) begin
          busyNext  = 1'b0;
          validNext = 1'b0;
        end else begin
          shiftNext = rData;
          laneNext  = '0;
          validNext = 1'b1;
        end
      end
      EMIT: begin
        if (abort) begin
          busyNext  = 1'b0;
          validNext = 1'b0;
        end else if (accept) begin
          shiftNext = shiftReg >> SAMPLE_WIDTH;
          laneNext  = lane + LANE_W'(1);
          indexNext = sampleIndex + SIW'(1);
          if (lastLane) begin
            validNext = 1'b0;
            if (wordsLeft > CW'(1)) begin
              rAddrNext     = rAddr + RAW'(1);
              wordsLeftNext = wordsLeft - CW'(1);
            end else begin
              busyNext = 1'b0;
              doneNext = 1'b1;
            end
          end
        end
      end
      default: begin
        busyNext  = 1'b0;
        validNext = 1'b0;
      end
    endcase
    lastNext = validNext && (wordsLeftNext == CW'(1)) && (laneNext == LANE_W'(SPC - 1));
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rAddr       <= '0;
      wordsLeft   <= '0;
      shiftReg    <= '0;
      lane        <= '0;
      sampleIndex <= '0;
      sampleValid <= 1'b0;
      sampleLast  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rAddr       <= rAddrNext;
      wordsLeft   <= wordsLeftNext;
      shiftReg    <= shiftNext;
      lane        <= laneNext;
      sampleIndex <= indexNext;
      sampleValid <= validNext;
      sampleLast  <= lastNext;
      busy        <= busyNext;
      done        <= doneNext;
    end
  end

endmodule

// File: tb/tb_dpram_sample_unpacker.sv
// Bench for dpram_sample_unpacker: table of runs checked against a queue
// model of the expected sample stream, plus hand-written abort/reset cases.
module tb_dpram_sample_unpacker;

  localparam int unsigned SW  = 14;
  localparam int unsigned WW  = 224;
  localparam int unsigned RAW = 10;
  localparam int unsigned CW  = RAW + 1;
  localparam int unsigned SPC = 16;
  localparam int unsigned SIW = 14;
  localparam int          BUDGET = 40000;

  logic           clk = 1'b0;
  logic           reset, start, abort, sampleReady;
  logic [RAW-1:0] startAddr, rAddr;
  logic [CW-1:0]  wordCount;
  logic [WW-1:0]  rData;
  logic [SW-1:0]  sampleData;
  logic [SIW-1:0] sampleIndex;
  logic           sampleValid, sampleLast, busy, done;

  always #5 clk = ~clk;

  dpram_sample_unpacker #(
    .SAMPLE_WIDTH(SW), .WORD_WIDTH(WW), .READ_ADDRESS_WIDTH(RAW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .startAddr(startAddr), .wordCount(wordCount), .rAddr(rAddr), .rData(rData),
    .sampleData(sampleData), .sampleIndex(sampleIndex), .sampleValid(sampleValid),
    .sampleReady(sampleReady), .sampleLast(sampleLast), .busy(busy), .done(done)
  );

  // RAM contents: word k, lane i = {k[5:0], i[3:0], 4'h0}.
  function automatic logic [WW-1:0] wordOf(input logic [RAW-1:0] k);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < SPC; i++) w[i*SW +: SW] = {k[5:0], 4'(i), 4'h0};
    return w;
  endfunction

  // Expected sample for a given write-side sample index.
  function automatic logic [SW-1:0] sampleOf(input int idx);
    return {6'(idx / SPC), 4'(idx % SPC), 4'h0};
  endfunction

  // DPRAM read port with one clock of latency.
  always_ff @(posedge clk) rData <= wordOf(rAddr);

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one run and check the whole stream against the queue model.
  task automatic doRun(input int sa, input int cnt, input bit randReady, input bit poke,
                       output int nSeen, output int firstIdx, output int lastIdx);
    int q[$];
    int e, cyc;
    bit r, prevStall, prevValid;
    logic [SW-1:0]  hData;
    logic [SIW-1:0] hIdx;
    logic           hLast;
    for (int w = 0; w < cnt; w++)
      for (int i = 0; i < SPC; i++) q.push_back(((sa + w) * SPC + i) % (1 << SIW));
    nSeen = 0; firstIdx = -1; lastIdx = -1;
    hData = '0; hIdx = '0; hLast = 1'b0;
    startAddr = RAW'(sa); wordCount = CW'(cnt); start = 1'b1; sampleReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("valid_after_start", 64'(sampleValid), 64'(0));
    prevStall = 1'b0; prevValid = 1'b0; cyc = 0;
    while (q.size() > 0 && cyc < BUDGET) begin
      check("done_during_run", 64'(done), 64'(0));
      if (sampleValid) begin
        if (!prevValid) check("rAddr_word", 64'(rAddr), 64'(q[0] / SPC));
        if (prevStall) begin
          check("hold_data", 64'(sampleData), 64'(hData));
          check("hold_index", 64'(sampleIndex), 64'(hIdx));
          check("hold_last", 64'(sampleLast), 64'(hLast));
        end
        r = randReady ? ($urandom_range(0, 99) < 60) : 1'b1;
        if (r) begin
          e = q.pop_front();
          check("data", 64'(sampleData), 64'(sampleOf(e)));
          check("index", 64'(sampleIndex), 64'(e));
          check("last", 64'(sampleLast), 64'(q.size() == 0));
          if (nSeen == 0) firstIdx = int'(sampleIndex);
          lastIdx = int'(sampleIndex);
          nSeen++;
        end
        prevStall = !r;
        hData = sampleData; hIdx = sampleIndex; hLast = sampleLast;
      end else begin
        r = 1'($urandom_range(0, 1));
        prevStall = 1'b0;
      end
      prevValid = sampleValid;
      sampleReady = r;
      if (poke && q.size() > 2) begin
        start = 1'b1; startAddr = RAW'($urandom); wordCount = CW'($urandom_range(0, 8));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; sampleReady = 1'b0;
    check("run_budget", 64'(cyc < BUDGET), 64'(1));
    check("done_pulse", 64'(done), 64'(1));
    check("busy_end", 64'(busy), 64'(0));
    check("valid_end", 64'(sampleValid), 64'(0));
    @(negedge clk);
    check("done_once", 64'(done), 64'(0));
  endtask

  typedef struct {
    int sa; int cnt; bit randReady; bit poke;
    int expSamples; int expFirst; int expLast;
  } runVecT;

  runVecT vecs[6];
  int nSeen, firstIdx, lastIdx;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sampleReady = 1'b0;
    startAddr = '0; wordCount = '0;
    repeat (3) @(negedge clk);
    check("rst_rAddr", 64'(rAddr), 64'(0));
    check("rst_valid", 64'(sampleValid), 64'(0));
    check("rst_last", 64'(sampleLast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_data", 64'(sampleData), 64'(0));
    check("rst_index", 64'(sampleIndex), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{sa: 5,    cnt: 2,    randReady: 1'b0, poke: 1'b0, expSamples: 32,    expFirst: 80,    expLast: 111};
    vecs[1] = '{sa: 5,    cnt: 2,    randReady: 1'b1, poke: 1'b0, expSamples: 32,    expFirst: 80,    expLast: 111};
    vecs[2] = '{sa: 1022, cnt: 4,    randReady: 1'b0, poke: 1'b1, expSamples: 64,    expFirst: 16352, expLast: 31};
    vecs[3] = '{sa: 1023, cnt: 1,    randReady: 1'b1, poke: 1'b0, expSamples: 16,    expFirst: 16368, expLast: 16383};
    vecs[4] = '{sa: 100,  cnt: 3,    randReady: 1'b1, poke: 1'b1, expSamples: 48,    expFirst: 1600,  expLast: 1647};
    vecs[5] = '{sa: 7,    cnt: 1024, randReady: 1'b0, poke: 1'b0, expSamples: 16384, expFirst: 112,   expLast: 111};
    for (int v = 0; v < 6; v++) begin
      doRun(vecs[v].sa, vecs[v].cnt, vecs[v].randReady, vecs[v].poke, nSeen, firstIdx, lastIdx);
      check("run_samples", 64'(nSeen), 64'(vecs[v].expSamples));
      check("run_first_idx", 64'(firstIdx), 64'(vecs[v].expFirst));
      check("run_last_idx", 64'(lastIdx), 64'(vecs[v].expLast));
    end

    // Zero-length run: done next cycle, never busy or valid.
    startAddr = 10'd9; wordCount = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cnt0_done", 64'(done), 64'(1));
    check("cnt0_busy", 64'(busy), 64'(0));
    check("cnt0_valid", 64'(sampleValid), 64'(0));
    @(negedge clk);
    check("cnt0_done_once", 64'(done), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("cnt0_no_valid", 64'(sampleValid | busy), 64'(0));
    end

    // start and abort together in IDLE: abort wins.
    startAddr = 10'd50; wordCount = 11'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'(0));
    wordCount = '0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_done", 64'(done), 64'(0));
    @(negedge clk);
    check("idle_abort_done2", 64'(done), 64'(0));

    // Abort during WAIT.
    startAddr = 10'd200; wordCount = 11'd3; start = 1'b1; sampleReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abortW_valid", 64'(sampleValid), 64'(0));
    check("abortW_busy", 64'(busy), 64'(0));
    check("abortW_done", 64'(done), 64'(0));
    @(negedge clk);
    check("abortW_done2", 64'(done), 64'(0));
    check("abortW_valid2", 64'(sampleValid), 64'(0));

    // Abort mid-EMIT, same cycle as a handshake.
    startAddr = 10'd300; wordCount = 11'd2; start = 1'b1; sampleReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abortE_valid_before", 64'(sampleValid), 64'(1));
    sampleReady = 1'b1;
    repeat (5) @(negedge clk);
    check("abortE_index_before", 64'(sampleIndex), 64'(300 * 16 + 5));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; sampleReady = 1'b0;
    check("abortE_valid", 64'(sampleValid), 64'(0));
    check("abortE_busy", 64'(busy), 64'(0));
    check("abortE_done", 64'(done), 64'(0));
    check("abortE_index_held", 64'(sampleIndex), 64'(300 * 16 + 5));
    @(negedge clk);
    check("abortE_done2", 64'(done), 64'(0));
    doRun(40, 1, 1'b1, 1'b0, nSeen, firstIdx, lastIdx);
    check("post_abort_samples", 64'(nSeen), 64'(16));
    check("post_abort_first", 64'(firstIdx), 64'(640));
    check("post_abort_last", 64'(lastIdx), 64'(655));

    // Synchronous reset mid-EMIT.
    startAddr = 10'd500; wordCount = 11'd2; start = 1'b1; sampleReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    sampleReady = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_rAddr", 64'(rAddr), 64'(0));
    check("mrst_valid", 64'(sampleValid), 64'(0));
    check("mrst_last", 64'(sampleLast), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_done", 64'(done), 64'(0));
    check("mrst_data", 64'(sampleData), 64'(0));
    check("mrst_index", 64'(sampleIndex), 64'(0));
    reset = 1'b0; sampleReady = 1'b0;
    @(negedge clk);
    check("mrst_after_busy", 64'(busy), 64'(0));
    check("mrst_after_done", 64'(done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
